// File: rtl/fir_audio_sequencer_if.sv
// Codec-side handshake bundle for fir_audio_sequencer.
// master: the sequencer (pops input FIFO, pushes output FIFO).
// slave : the codec FIFO side.
interface fir_audio_sequencer_if #(
    parameter int WIDTH = 24
);
    logic             read_ready;
    logic [WIDTH-1:0] readdata_left;
    logic [WIDTH-1:0] readdata_right;
    logic             write_ready;
    logic             read;
    logic             write;
    logic [WIDTH-1:0] writedata_left;
    logic [WIDTH-1:0] writedata_right;
    logic             busy;

    modport master (
        input  read_ready, readdata_left, readdata_right, write_ready,
        output read, write, writedata_left, writedata_right, busy
    );

    modport slave (
        output read_ready, readdata_left, readdata_right, write_ready,
        input  read, write, writedata_left, writedata_right, busy
    );
endinterface

// File: rtl/fir_audio_sequencer.sv
// Time-multiplexed stereo moving-average FIR between the codec FIFOs.
// One tap per clock per channel; TAPS-deep history ring per channel.
// Optional feature macro: FIR_BYPASS_EN (adds a `bypass` input that routes the
// raw sample straight to the output, skipping accumulation).
module fir_audio_sequencer #(
    parameter int WIDTH = 24,
    parameter int TAPS  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
`ifdef FIR_BYPASS_EN
    input  logic                  bypass,
`endif
    fir_audio_sequencer_if.master bus
);
    localparam int SHIFT = $clog2(TAPS);
    localparam int PTR_W = SHIFT;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         k_q, k_d;
    logic signed [WIDTH-1:0]  acc_l_q, acc_l_d;
    logic signed [WIDTH-1:0]  acc_r_q, acc_r_d;
    logic [WIDTH-1:0]         wd_l_q, wd_l_d;
    logic [WIDTH-1:0]         wd_r_q, wd_r_d;
    logic                     read_q, read_d;
    logic                     write_q, write_d;
    logic                     busy_q, busy_d;
    logic                     hist_we;

    logic signed [WIDTH-1:0]  hist_l_q [TAPS];
    logic signed [WIDTH-1:0]  hist_r_q [TAPS];

    // Newest sample sits at wr_ptr; k walks backwards through the ring.
    logic [PTR_W-1:0]         rd_idx;
    logic signed [WIDTH-1:0]  term_l, term_r;
    logic signed [WIDTH-1:0]  sum_l, sum_r;

    assign rd_idx = wr_ptr_q - k_q;
    assign term_l = hist_l_q[rd_idx] >>> SHIFT;
    assign term_r = hist_r_q[rd_idx] >>> SHIFT;
    // Pre-scaled terms cannot overflow WIDTH when summed over TAPS taps.
    assign sum_l  = acc_l_q + term_l;
    assign sum_r  = acc_r_q + term_r;

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        wd_l_d   = wd_l_q;
        wd_r_d   = wd_r_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        hist_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.read_ready) begin
                    hist_we = 1'b1;
                    read_d  = 1'b1;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    k_d     = '0;
                    state_d = ACCUM;
`ifdef FIR_BYPASS_EN
                    if (bypass) begin
                        wd_l_d  = bus.readdata_left;
                        wd_r_d  = bus.readdata_right;
                        state_d = OUT;
                    end
`endif
                end
            end
            ACCUM: begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
                k_d     = k_q + 1'b1;
                if (k_q == PTR_W'(TAPS - 1)) begin
                    // Output register loads with the final sum on the way into OUT.
                    wd_l_d  = sum_l;
                    wd_r_d  = sum_r;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.write_ready) begin
                    write_d  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchronous reset aborts any sample in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            k_q      <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            wd_l_q   <= '0;
            wd_r_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            k_q      <= k_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            wd_l_q   <= wd_l_d;
            wd_r_q   <= wd_r_d;
            read_q   <= read_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
        end
    end

    // History rings: one write per accepted sample, cleared on reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_l_q[i] <= '0;
                hist_r_q[i] <= '0;
            end
        end else if (hist_we) begin
            hist_l_q[wr_ptr_q] <= bus.readdata_left;
            hist_r_q[wr_ptr_q] <= bus.readdata_right;
        end
    end

    assign bus.read            = read_q;
    assign bus.write           = write_q;
    assign bus.writedata_left  = wd_l_q;
    assign bus.writedata_right = wd_r_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_fir_audio_sequencer.sv
// Self-checking bench for fir_audio_sequencer (WIDTH=24, TAPS=8).
// Reference: output = sum of the last 8 accepted samples, each >>> 3, truncated to 24 bits.
module tb_fir_audio_sequencer;
    typedef logic signed [23:0] smp_t;

    logic clock;
    logic reset_n;
`ifdef FIR_BYPASS_EN
    logic bypass;
`endif
    int   errors;
    int   checks;
    smp_t ql[$];
    smp_t qr[$];

    fir_audio_sequencer_if #(.WIDTH(24)) bus ();

    fir_audio_sequencer #(.WIDTH(24), .TAPS(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
`ifdef FIR_BYPASS_EN
        .bypass  (bypass),
`endif
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Moving average over the most recent 8 samples (missing entries count as 0).
    function automatic logic [23:0] model_avg(input smp_t q[$]);
        int   acc;
        smp_t s;
        acc = 0;
        foreach (q[i]) begin
            s = q[i] >>> 3;
            acc += int'(s);
        end
        return acc[23:0];
    endfunction

    function automatic void model_push(input smp_t l, input smp_t r);
        ql.push_front(l);
        qr.push_front(r);
        if (ql.size() > 8) void'(ql.pop_back());
        if (qr.size() > 8) void'(qr.pop_back());
    endfunction

    function automatic void model_clear();
        ql.delete();
        qr.delete();
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    // Feeds one sample and waits (bounded) for the matching write pulse.
    // lat = cycles from the read pulse to the write pulse; ok=0 on no read or timeout.
    task automatic do_sample(input logic [23:0] l, input logic [23:0] r,
                             output logic [23:0] ol, output logic [23:0] orr,
                             output int lat, output bit ok);
        int n;
        ok = 1'b0;
        lat = -1;
        ol = 'x;
        orr = 'x;
        n = 0;
        while (bus.busy && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        bus.readdata_left  = l;
        bus.readdata_right = r;
        bus.read_ready     = 1'b1;
        @(posedge clock);
        #1;
        bus.read_ready = 1'b0;
        if (bus.read !== 1'b1) return;
        for (int c = 1; c < 200; c++) begin
            @(posedge clock);
            #1;
            if (bus.write === 1'b1) begin
                ol  = bus.writedata_left;
                orr = bus.writedata_right;
                lat = c;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: read=%b write=%b busy=%b, required 0 0 0", bus.read, bus.write, bus.busy);
        end
        checks++;
        if (bus.writedata_left !== 24'h0 || bus.writedata_right !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: L=%h R=%h, required 0 0", bus.writedata_left, bus.writedata_right);
        end
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_step();
        logic [23:0] ol, orr, el;
        int lat;
        bit ok;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_sample(24'h000800, 24'h000800, ol, orr, lat, ok);
            model_push(24'sh000800, 24'sh000800);
            el = model_avg(ql);
            checks++;
            if (!ok || ol !== el || orr !== model_avg(qr)) begin
                errors++;
                $display("FAIL step[%0d]: ok=%0b L=%h R=%h, required L=%h R=%h", i, ok, ol, orr, el, model_avg(qr));
            end
            if (i == 0) begin
                checks++;
                if (lat != 9) begin
                    errors++;
                    $display("FAIL step_latency: got %0d cycles, required 9", lat);
                end
            end
        end
        checks++;
        if (ol !== 24'h000800) begin
            errors++;
            $display("FAIL step_final: got %h, required 000800", ol);
        end
    endtask

    task automatic test_neg_impulse();
        logic [23:0] ol, orr, el, er;
        int lat;
        bit ok;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                do_sample(24'hFFF800, 24'h0, ol, orr, lat, ok);
                model_push(24'shFFF800, 24'sh0);
            end else begin
                do_sample(24'h0, 24'h0, ol, orr, lat, ok);
                model_push(24'sh0, 24'sh0);
            end
            el = model_avg(ql);
            er = model_avg(qr);
            checks++;
            if (!ok || ol !== el || orr !== er) begin
                errors++;
                $display("FAIL neg_impulse[%0d]: ok=%0b L=%h R=%h, required L=%h R=%h", i, ok, ol, orr, el, er);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] el;
        int bad;
        apply_reset();
        bus.write_ready    = 1'b0;
        bus.readdata_left  = 24'h000800;
        bus.readdata_right = 24'hFFF000;
        bus.read_ready     = 1'b1;
        @(posedge clock);
        #1;
        bus.read_ready = 1'b0;
        model_push(24'sh000800, 24'shFFF000);
        el = model_avg(ql);
        checks++;
        if (bus.read !== 1'b1) begin
            errors++;
            $display("FAIL bp_read: read=%b, required 1", bus.read);
        end
        bad = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock);
            #1;
            if (bus.write !== 1'b0 || bus.read !== 1'b0 || bus.busy !== 1'b1) bad++;
            if (i >= 8 && (bus.writedata_left !== el || bus.writedata_right !== model_avg(qr))) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles while stalled, required 0 (L=%h exp %h)", bad, bus.writedata_left, el);
        end
        bus.write_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (bus.write !== 1'b1 || bus.read !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: write=%b read=%b, required 1 0", bus.write, bus.read);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.write !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_pulse: write=%b busy=%b, required 0 0", bus.write, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] ol, orr;
        int lat, wcount;
        bit ok;
        apply_reset();
        bus.readdata_left  = 24'h000800;
        bus.readdata_right = 24'h000400;
        bus.read_ready     = 1'b1;
        @(posedge clock);
        #1;
        bus.read_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_clear();
        checks++;
        if (bus.busy !== 1'b0 || bus.writedata_left !== 24'h0 || bus.writedata_right !== 24'h0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b L=%h R=%h, required 0 0 0", bus.busy, bus.writedata_left, bus.writedata_right);
        end
        wcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            if (bus.write === 1'b1) wcount++;
        end
        checks++;
        if (wcount != 0) begin
            errors++;
            $display("FAIL midreset_nowrite: %0d writes, required 0", wcount);
        end
        do_sample(24'h000800, 24'h000800, ol, orr, lat, ok);
        model_push(24'sh000800, 24'sh000800);
        checks++;
        if (!ok || ol !== 24'h000100 || ol !== model_avg(ql)) begin
            errors++;
            $display("FAIL midreset_next: ok=%0b L=%h, required 000100", ok, ol);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] ol, orr, el;
        int lat, bad;
        bit ok;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 17 * 8; i++) begin
            if (i % 8 == 0) begin
                do_sample(24'h000008, 24'h000008, ol, orr, lat, ok);
                model_push(24'sh000008, 24'sh000008);
            end else begin
                do_sample(24'h0, 24'h0, ol, orr, lat, ok);
                model_push(24'sh0, 24'sh0);
            end
            el = model_avg(ql);
            if (!ok || ol !== el || orr !== el || el !== 24'h000001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap: %0d wrong outputs over 136 samples, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [23:0] ol, orr, l, r;
        int lat;
        bit ok;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            l = 24'($urandom);
            r = 24'($urandom);
            do_sample(l, r, ol, orr, lat, ok);
            model_push(l, r);
            checks++;
            if (!ok || ol !== model_avg(ql) || orr !== model_avg(qr)) begin
                errors++;
                $display("FAIL random[%0d]: ok=%0b L=%h R=%h, required L=%h R=%h", i, ok, ol, orr, model_avg(ql), model_avg(qr));
            end
        end
    endtask

`ifdef FIR_BYPASS_EN
    task automatic test_bypass();
        logic [23:0] ol, orr;
        int lat;
        bit ok;
        apply_reset();
        bypass = 1'b1;
        do_sample(24'h123456, 24'h0ABCDE, ol, orr, lat, ok);
        bypass = 1'b0;
        model_push(24'sh123456, 24'sh0ABCDE);
        checks++;
        if (!ok || ol !== 24'h123456 || orr !== 24'h0ABCDE || lat != 1) begin
            errors++;
            $display("FAIL bypass: ok=%0b L=%h R=%h lat=%0d, required 123456 0ABCDE 1", ok, ol, orr, lat);
        end
        do_sample(24'h0, 24'h0, ol, orr, lat, ok);
        model_push(24'sh0, 24'sh0);
        checks++;
        if (!ok || ol !== model_avg(ql) || orr !== model_avg(qr)) begin
            errors++;
            $display("FAIL bypass_history: L=%h R=%h, required L=%h R=%h", ol, orr, model_avg(ql), model_avg(qr));
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
`ifdef FIR_BYPASS_EN
        bypass = 1'b0;
`endif
        bus.read_ready     = 1'b0;
        bus.readdata_left  = '0;
        bus.readdata_right = '0;
        bus.write_ready    = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_step();
        test_neg_impulse();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
`ifdef FIR_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
